// File: rtl/reg_file_if.sv
// reg_file_if: bundles the commit, issue and read-port signals of reg_file.
//   Control   : rdy_in (global enable), clear (ROB flush)
//   Commit    : en_commit, ROB_Number, Reg_Number, Reg_Val
//   Issue     : ISSUE_in, rd_in, ROB_Number_in
//   Read ports: rs1_in/rs2_in -> rs1_/rs2_ val, busy, tag
// The master modport drives requests; the slave modport is the register file.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              rdy_in;
  logic              clear;
  logic              en_commit;
  logic [TAG_W-1:0]  ROB_Number;
  logic [4:0]        Reg_Number;
  logic [DATA_W-1:0] Reg_Val;
  logic              ISSUE_in;
  logic [4:0]        rd_in;
  logic [TAG_W-1:0]  ROB_Number_in;
  logic [4:0]        rs1_in;
  logic [4:0]        rs2_in;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [TAG_W-1:0]  rs1_tag;
  logic [TAG_W-1:0]  rs2_tag;

  modport master (
    output rdy_in, clear, en_commit, ROB_Number, Reg_Number, Reg_Val,
           ISSUE_in, rd_in, ROB_Number_in, rs1_in, rs2_in,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy_in, clear, en_commit, ROB_Number, Reg_Number, Reg_Val,
           ISSUE_in, rd_in, ROB_Number_in, rs1_in, rs2_in,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: architectural register file with rename (busy/tag) state for an
// out-of-order core fed by a reorder buffer.
//   clk_in : single clock, rising edge
//   rst_in : asynchronous active-high reset, clears val/busy/tag
//   bus    : reg_file_if.slave (commit, issue, flush, two read ports)
// Register 0 holds no state and always reads 0/0/0.
// Optional macro REGFILE_COMMIT_BYPASS_EN: forwards a retiring commit value
// straight to a read port in the same cycle.
module reg_file #(
  parameter int REG_CNT = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  reg_file_if.slave   bus
);

  logic [DATA_W-1:0] val_q  [1:REG_CNT-1];
  logic [DATA_W-1:0] val_d  [1:REG_CNT-1];
  logic              busy_q [1:REG_CNT-1];
  logic              busy_d [1:REG_CNT-1];
  logic [TAG_W-1:0]  tag_q  [1:REG_CNT-1];
  logic [TAG_W-1:0]  tag_d  [1:REG_CNT-1];

  // Next-state: commit writes the value, and retires the rename only when the
  // committing tag is still the newest producer. Issue is applied after commit
  // so a same-cycle rename wins the busy/tag fields. Flush drops all renames.
  always_comb begin
    for (int i = 1; i < REG_CNT; i++) begin
      val_d[i]  = val_q[i];
      busy_d[i] = busy_q[i];
      tag_d[i]  = tag_q[i];
      if (bus.rdy_in) begin
        if (bus.en_commit && (bus.Reg_Number == 5'(i))) begin
          val_d[i] = bus.Reg_Val;
          if (busy_q[i] && (tag_q[i] == bus.ROB_Number)) begin
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
          end
        end
        if (bus.clear) begin
          busy_d[i] = 1'b0;
          tag_d[i]  = '0;
        end else if (bus.ISSUE_in && (bus.rd_in == 5'(i))) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = bus.ROB_Number_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 1; i < REG_CNT; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < REG_CNT; i++) begin
        val_q[i]  <= val_d[i];
        busy_q[i] <= busy_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  // Read ports: address decode by loop so that rs==0 and addresses beyond
  // REG_CNT naturally fall through to the 0/0/0 defaults. Reads see only
  // registered state, so an issue in the same cycle is not visible yet.
  always_comb begin
    bus.rs1_val  = '0;
    bus.rs1_busy = 1'b0;
    bus.rs1_tag  = '0;
    bus.rs2_val  = '0;
    bus.rs2_busy = 1'b0;
    bus.rs2_tag  = '0;
    for (int i = 1; i < REG_CNT; i++) begin
      if (bus.rs1_in == 5'(i)) begin
        bus.rs1_val  = val_q[i];
        bus.rs1_busy = busy_q[i];
        bus.rs1_tag  = busy_q[i] ? tag_q[i] : '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (bus.en_commit && (bus.Reg_Number == 5'(i)) && busy_q[i] &&
            (tag_q[i] == bus.ROB_Number)) begin
          bus.rs1_val  = bus.Reg_Val;
          bus.rs1_busy = 1'b0;
          bus.rs1_tag  = '0;
        end
`endif
      end
      if (bus.rs2_in == 5'(i)) begin
        bus.rs2_val  = val_q[i];
        bus.rs2_busy = busy_q[i];
        bus.rs2_tag  = busy_q[i] ? tag_q[i] : '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (bus.en_commit && (bus.Reg_Number == 5'(i)) && busy_q[i] &&
            (tag_q[i] == bus.ROB_Number)) begin
          bus.rs2_val  = bus.Reg_Val;
          bus.rs2_busy = 1'b0;
          bus.rs2_tag  = '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (default parameters).
module tb_reg_file;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_file_if #(.DATA_W(32), .TAG_W(5)) bus ();

  reg_file #(.REG_CNT(32), .DATA_W(32), .TAG_W(5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.clear         = 1'b0;
    bus.en_commit     = 1'b0;
    bus.ROB_Number    = '0;
    bus.Reg_Number    = '0;
    bus.Reg_Val       = '0;
    bus.ISSUE_in      = 1'b0;
    bus.rd_in         = '0;
    bus.ROB_Number_in = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] tag);
    bus.ISSUE_in = 1'b1; bus.rd_in = rd; bus.ROB_Number_in = tag;
  endtask

  task automatic commit(input logic [4:0] rn, input logic [4:0] tag, input logic [31:0] v);
    bus.en_commit = 1'b1; bus.Reg_Number = rn; bus.ROB_Number = tag; bus.Reg_Val = v;
  endtask

  task automatic rd1(input string n, input logic [31:0] v, input logic b, input logic [4:0] t);
    chk({n, "_val1"}, bus.rs1_val, v);
    chk({n, "_busy1"}, {31'd0, bus.rs1_busy}, {31'd0, b});
    chk({n, "_tag1"}, {27'd0, bus.rs1_tag}, {27'd0, t});
  endtask

  task automatic rd2(input string n, input logic [31:0] v, input logic b, input logic [4:0] t);
    chk({n, "_val2"}, bus.rs2_val, v);
    chk({n, "_busy2"}, {31'd0, bus.rs2_busy}, {31'd0, b});
    chk({n, "_tag2"}, {27'd0, bus.rs2_tag}, {27'd0, t});
  endtask

  initial begin
    bus.rdy_in = 1'b1;
    bus.rs1_in = 5'd5;
    bus.rs2_in = 5'd0;
    idle();
    tick(); tick();
    rst_in = 1'b0;
    #1;
    rd1("reset_x5", 32'h0, 1'b0, 5'd0);
    rd2("reset_x0", 32'h0, 1'b0, 5'd0);

    // issue x3 tag 7; same-cycle read shows pre-issue state
    bus.rs1_in = 5'd3;
    issue(5'd3, 5'd7);
    #1;
    rd1("issue_pre", 32'h0, 1'b0, 5'd0);
    tick(); idle(); #1;
    rd1("issue_x3", 32'h0, 1'b1, 5'd7);
    commit(5'd3, 5'd7, 32'hDEADBEEF);
    tick(); idle(); #1;
    rd1("commit_x3", 32'hDEADBEEF, 1'b0, 5'd0);

    // two producers for x4; older commit keeps newer rename
    issue(5'd4, 5'd2); tick();
    issue(5'd4, 5'd9); tick(); idle();
    commit(5'd4, 5'd2, 32'h11); tick(); idle();
    bus.rs1_in = 5'd4; #1;
    rd1("stale_commit_x4", 32'h11, 1'b1, 5'd9);

    // same-cycle commit of newest producer and new issue
    commit(5'd4, 5'd9, 32'h22); issue(5'd4, 5'd12); tick(); idle(); #1;
    rd1("commit_issue_x4", 32'h22, 1'b1, 5'd12);

    // flush with concurrent commit and issue
    issue(5'd6, 5'd1); tick();
    issue(5'd7, 5'd2); tick(); idle();
    bus.rs1_in = 5'd6; bus.rs2_in = 5'd7; #1;
    rd1("pre_clear_x6", 32'h0, 1'b1, 5'd1);
    rd2("pre_clear_x7", 32'h0, 1'b1, 5'd2);
    bus.clear = 1'b1; commit(5'd6, 5'd1, 32'h55); issue(5'd8, 5'd4);
    tick(); idle(); #1;
    rd1("clear_x6", 32'h55, 1'b0, 5'd0);
    rd2("clear_x7", 32'h0, 1'b0, 5'd0);
    bus.rs1_in = 5'd8; bus.rs2_in = 5'd4; #1;
    rd1("clear_x8", 32'h0, 1'b0, 5'd0);
    rd2("clear_x4", 32'h22, 1'b0, 5'd0);

    // commit read in the same cycle (bypass depends on build)
    issue(5'd10, 5'd3); tick(); idle();
    bus.rs1_in = 5'd10;
    commit(5'd10, 5'd3, 32'h99); #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
    rd1("same_cycle_x10", 32'h99, 1'b0, 5'd0);
`else
    rd1("same_cycle_x10", 32'h0, 1'b1, 5'd3);
`endif
    tick(); idle(); #1;
    rd1("after_x10", 32'h99, 1'b0, 5'd0);

    // register 0 discards writes and renames
    issue(5'd0, 5'd5); commit(5'd0, 5'd5, 32'h1234);
    tick(); idle();
    bus.rs1_in = 5'd0; #1;
    rd1("x0", 32'h0, 1'b0, 5'd0);

    // rdy_in low freezes state, reads stay valid
    bus.rdy_in = 1'b0;
    issue(5'd12, 5'd6); commit(5'd3, 5'd0, 32'hAAAA);
    bus.rs1_in = 5'd12; bus.rs2_in = 5'd3;
    tick(); tick(); idle(); #1;
    rd2("frozen_x3_read", 32'hDEADBEEF, 1'b0, 5'd0);
    bus.rdy_in = 1'b1; #1;
    rd1("frozen_x12", 32'h0, 1'b0, 5'd0);
    rd2("frozen_x3", 32'hDEADBEEF, 1'b0, 5'd0);

    // asynchronous reset mid-operation
    issue(5'd13, 5'd8); tick(); idle();
    bus.rs1_in = 5'd13; #1;
    rd1("pre_rst_x13", 32'h0, 1'b1, 5'd8);
    #2 rst_in = 1'b1;
    commit(5'd3, 5'd0, 32'h77); issue(5'd3, 5'd1); #1;
    rd1("rst_x13", 32'h0, 1'b0, 5'd0);
    rd2("rst_x3", 32'h0, 1'b0, 5'd0);
    tick();
    rd2("rst_hold_x3", 32'h0, 1'b0, 5'd0);
    rst_in = 1'b0; idle();
    issue(5'd3, 5'd1); tick(); idle(); #1;
    rd2("post_rst_x3", 32'h0, 1'b1, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
